// File: rtl/spi_pkg.sv
// Shared types and widths for the SPI command master and its slave-side peers.
package spi_pkg;

  localparam int unsigned CMD_W     = 10;
  localparam int unsigned DATA_W    = 8;
  localparam int unsigned OP_W      = 2;
  localparam int unsigned PAYLOAD_W = CMD_W - OP_W;
  localparam int unsigned CNT_W     = 4;

  typedef enum logic [1:0] {
    OP_WR_ADDR = 2'b00,
    OP_WR_DATA = 2'b01,
    OP_RD_ADDR = 2'b10,
    OP_RD_DATA = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    WAIT,
    RECV,
    END
  } mst_state_e;

  // Command frame as sent on the wire, MSB first.
  typedef struct packed {
    op_e                  op;
    logic [PAYLOAD_W-1:0] payload;
  } cmd_t;

endpackage

// File: rtl/spi_cmd_master.sv
// SPI command master: serialises host commands onto ss_n/mosi at one bit per clk
// and returns the miso reply of read-data frames.
module spi_cmd_master
  import spi_pkg::*;
#(
  parameter int unsigned RD_WAIT = 2,
  parameter int unsigned GAP     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CMD_W-1:0]  cmd_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              ss_n,
  output logic              mosi,
  input  logic              miso
);

  localparam logic [CNT_W-1:0] SHIFT_FIRST = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] RECV_LAST   = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP - 1);

  mst_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  cmd_t              shreg_q, shreg_d;
  logic [DATA_W-2:0] rx_q, rx_d;
  logic [DATA_W-1:0] rd_data_d;
  logic              rd_valid_d;
  logic              busy_d;
  logic              cmd_ready_d;
  logic              ss_n_d;
  logic              mosi_d;

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      rx_q      <= '0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b0;
      ss_n      <= 1'b1;
      mosi      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      rx_q      <= rx_d;
      rd_data   <= rd_data_d;
      rd_valid  <= rd_valid_d;
      busy      <= busy_d;
      cmd_ready <= cmd_ready_d;
      ss_n      <= ss_n_d;
      mosi      <= mosi_d;
    end
  end

  // Next state plus the values the output registers take on entering it.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shreg_d    = shreg_q;
    rx_d       = rx_q;
    rd_data_d  = rd_data;
    rd_valid_d = 1'b0;
    ss_n_d     = ss_n;
    mosi_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          shreg_d = cmd_t'(cmd_data);
          ss_n_d  = 1'b0;
          mosi_d  = cmd_data[CMD_W-1];
          state_d = START;
        end
      end

      START: begin
        cnt_d   = SHIFT_FIRST;
        mosi_d  = shreg_q[CMD_W-1];
        state_d = SHIFT;
      end

      SHIFT: begin
        if (cnt_q == '0) begin
          if (shreg_q.op == OP_RD_DATA) begin
            cnt_d   = WAIT_LAST;
            state_d = WAIT;
          end else begin
            cnt_d   = GAP_LAST;
            ss_n_d  = 1'b1;
            state_d = END;
          end
        end else begin
          cnt_d  = cnt_q - CNT_W'(1);
          mosi_d = shreg_q[cnt_d];
        end
      end

      WAIT: begin
        if (cnt_q == '0) begin
          cnt_d   = RECV_LAST;
          state_d = RECV;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      // miso is only ever looked at here, so X elsewhere cannot leak in.
      RECV: begin
        rx_d = {rx_q[DATA_W-3:0], miso};
        if (cnt_q == '0) begin
          rd_data_d  = {rx_q, miso};
          rd_valid_d = 1'b1;
          ss_n_d     = 1'b1;
          cnt_d      = GAP_LAST;
          state_d    = END;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      END: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        ss_n_d  = 1'b1;
        state_d = IDLE;
      end
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

endmodule

// File: tb/tb_spi_cmd_master.sv
// Self-checking bench for spi_cmd_master: directed scenarios plus randomized
// frames against a cycle-level frame model and a small RAM slave model.
module tb_spi_cmd_master;

  localparam int RD_WAIT = 2;
  localparam int GAP     = 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [9:0] cmd_data;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;
  logic       ss_n;
  logic       mosi;
  logic       miso;

  int checks = 0;
  int errors = 0;

  logic [7:0] last_rd;
  logic [7:0] mem [256];
  logic [7:0] wr_addr;
  logic [7:0] rd_addr;

  always #5 clk = ~clk;

  spi_cmd_master #(
    .RD_WAIT (RD_WAIT),
    .GAP     (GAP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy),
    .ss_n      (ss_n),
    .mosi      (mosi),
    .miso      (miso)
  );

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // RAM slave behaviour: returns the reply a read-data frame would carry.
  function automatic logic [7:0] slave_step(input logic [9:0] c);
    logic [7:0] r;
    r = 8'h00;
    case (c[9:8])
      2'b00:   wr_addr = c[7:0];
      2'b01:   mem[wr_addr] = c[7:0];
      2'b10:   rd_addr = c[7:0];
      default: r = mem[rd_addr];
    endcase
    return r;
  endfunction

  // One whole frame, checked cycle by cycle. vmode: 0 cmd_valid low while busy,
  // 1 random junk handshakes while busy, 2 hold cmd_valid with 'other' queued.
  task automatic do_frame(input logic [9:0] cmd, input logic [7:0] reply,
                          input bit x_miso, input int vmode, input logic [9:0] other);
    int guard;
    int low;
    int total;
    bit is_rd;
    logic [9:0] sh;
    logic [7:0] rs;
    logic exp_mosi;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk1("ready_wait", (guard < 100) ? 1'b1 : 1'b0, 1'b1);
    cmd_valid = 1'b1;
    cmd_data  = cmd;
    @(posedge clk);
    is_rd = (cmd[9:8] == 2'b11);
    low   = 11 + (is_rd ? RD_WAIT + 8 : 0);
    total = low + GAP + 1;
    sh = cmd;
    rs = reply;
    for (int k = 1; k <= total; k++) begin
      @(negedge clk);
      if (k == 1) begin
        exp_mosi = cmd[9];
      end else if (k <= 11) begin
        exp_mosi = sh[9];
        sh = sh << 1;
      end else begin
        exp_mosi = 1'b0;
      end
      chk1("ss_n", ss_n, (k <= low) ? 1'b0 : 1'b1);
      chk1("mosi", mosi, exp_mosi);
      chk1("rd_valid", rd_valid, (is_rd && k == low + 1) ? 1'b1 : 1'b0);
      chk1("cmd_ready", cmd_ready, (k == total) ? 1'b1 : 1'b0);
      chk1("busy", busy, (k < total) ? 1'b1 : 1'b0);
      if (is_rd && k == low + 1) last_rd = reply;
      if (k == 1 || k == low + 1) chk8("rd_data", rd_data, last_rd);
      // Reply bits occupy the receive window; everything else is noise or X.
      if (is_rd && k >= 12 + RD_WAIT && k < 20 + RD_WAIT) begin
        miso = rs[7];
        rs = rs << 1;
      end else begin
        miso = x_miso ? 1'bx : 1'($urandom_range(0, 1));
      end
      if (k < total || vmode == 2) begin
        case (vmode)
          1: begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_data  = other;
          end
          2: begin
            cmd_valid = 1'b1;
            cmd_data  = other;
          end
          default: cmd_valid = 1'b0;
        endcase
      end else begin
        cmd_valid = 1'b0;
      end
    end
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk1("idle_ss_n", ss_n, 1'b1);
      chk1("idle_mosi", mosi, 1'b0);
      chk1("idle_busy", busy, 1'b0);
      chk1("idle_ready", cmd_ready, 1'b1);
      chk1("idle_rd_valid", rd_valid, 1'b0);
    end
  endtask

  task automatic ram_frame(input logic [9:0] c);
    logic [7:0] r;
    r = slave_step(c);
    do_frame(c, r, 1'b0, 0, 10'h000);
    idle_check(1);
  endtask

  initial begin
    logic [9:0] cur;
    logic [9:0] nxt;
    logic [7:0] r;
    int vm;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = '0;
    miso      = 1'b0;
    last_rd   = 8'h00;
    wr_addr   = 8'h00;
    rd_addr   = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    repeat (3) @(negedge clk);
    chk1("rst_ss_n", ss_n, 1'b1);
    chk1("rst_mosi", mosi, 1'b0);
    chk1("rst_rd_valid", rd_valid, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk8("rst_rd_data", rd_data, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    chk1("ready_after_reset", cmd_ready, 1'b1);

    // Plain write-address frame.
    do_frame(10'b00_0000_0101, 8'h00, 1'b0, 0, 10'h000);
    idle_check(3);

    // Write then read back one RAM location.
    ram_frame(10'h005);
    ram_frame(10'h1A7);
    ram_frame(10'h205);
    ram_frame(10'h300);
    chk8("ram_readback", rd_data, 8'hA7);

    // Fixed reply, then a write frame must leave rd_data alone.
    do_frame(10'h3FF, 8'h3C, 1'b0, 0, 10'h000);
    do_frame(10'h155, 8'h00, 1'b0, 0, 10'h000);
    chk8("rd_hold", rd_data, 8'h3C);
    idle_check(2);

    // Back-to-back frames with cmd_valid held high.
    do_frame(10'h012, 8'h00, 1'b0, 2, 10'h134);
    do_frame(10'h134, 8'h00, 1'b0, 2, 10'h3C0);
    do_frame(10'h3C0, 8'h96, 1'b0, 0, 10'h000);
    idle_check(2);

    // Abort a read-data frame mid-shift.
    cmd_valid = 1'b1;
    cmd_data  = 10'h3C3;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    chk1("pre_abort_ss_n", ss_n, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk1("abort_ss_n", ss_n, 1'b1);
    chk1("abort_mosi", mosi, 1'b0);
    chk1("abort_rd_valid", rd_valid, 1'b0);
    chk1("abort_busy", busy, 1'b0);
    chk8("abort_rd_data", rd_data, 8'h00);
    last_rd = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk1("ready_after_abort", cmd_ready, 1'b1);
    idle_check(25);
    do_frame(10'h0A5, 8'h00, 1'b0, 0, 10'h000);
    idle_check(2);

    // X on miso outside the receive window and junk handshakes while busy.
    do_frame(10'h06B, 8'h00, 1'b1, 1, 10'h2AA);
    idle_check(3);
    do_frame(10'h311, 8'h5A, 1'b1, 1, 10'h1FF);
    idle_check(3);

    // Randomized command stream against the RAM slave model.
    nxt = 10'($urandom);
    for (int i = 0; i < 40; i++) begin
      cur = nxt;
      nxt = 10'($urandom);
      vm  = int'($urandom_range(0, 2));
      r   = slave_step(cur);
      do_frame(cur, r, 1'($urandom_range(0, 1)), vm, (vm == 2) ? nxt : 10'($urandom));
      if (vm != 2) idle_check(int'($urandom_range(0, 2)));
    end
    r = slave_step(nxt);
    do_frame(nxt, r, 1'b0, 0, 10'h000);
    idle_check(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
